// File: rtl/rf_sched_pkg.sv
// ============================================================================
// Module      : rf_sched_pkg
// Description : Shared state encoding, register-file geometry and init values
//               for the register-file write scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_sched_pkg;

  localparam int          c_num_regs = 32;
  localparam int          c_reg_aw   = 5;
  localparam logic [31:0] c_sp_init  = 32'h0000_01F4;
  localparam logic [31:0] c_gp_init  = 32'h1000_0000;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_t;

  function automatic logic [c_num_regs-1:0] rd_decode(input logic [c_reg_aw-1:0] rd);
    return {{(c_num_regs-1){1'b0}}, 1'b1} << rd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_wr_fifo.sv
// ============================================================================
// Module      : rf_wr_fifo
// Description : Holding queue for long-latency writes; exposes every entry's
//               rd and valid flag so the owner can build a busy mask.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wr_fifo #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [AW-1:0]              i_push_rd,
  input  logic [DW-1:0]              i_push_data,
  input  logic                       i_pop,
  output logic [AW-1:0]              o_head_rd,
  output logic [DW-1:0]              o_head_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic [DEPTH-1:0][AW-1:0]   o_ent_rd,
  output logic [DEPTH-1:0]           o_ent_vld
);

  localparam int c_pw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cw = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0][AW-1:0] r_rd;
  logic [DEPTH-1:0][DW-1:0] r_data;
  logic [c_pw-1:0]          r_wptr;
  logic [c_pw-1:0]          r_rptr;
  logic [c_cw-1:0]          r_count;
  logic                     w_full;
  logic                     w_push;
  logic                     w_pop;

  assign o_empty = (r_count == '0);
  assign w_full  = (r_count == c_cw'(DEPTH));
  assign w_push  = i_push & ~w_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_pw'(1);
      if (w_pop)  r_rptr <= r_rptr + c_pw'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by pointers/count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wptr]   <= i_push_rd;
      r_data[r_wptr] <= i_push_data;
    end
  end

  assign o_head_rd   = r_rd[r_rptr];
  assign o_head_data = r_data[r_rptr];
  assign o_count     = r_count;
  assign o_ent_rd    = r_rd;

  for (genvar i = 0; i < DEPTH; i++) begin : g_vld
    logic [c_pw-1:0] w_off;
    assign w_off        = c_pw'(i) - r_rptr;
    assign o_ent_vld[i] = ({1'b0, w_off} < r_count);
  end

endmodule

`default_nettype wire

// File: rtl/rf_write_scheduler.sv
// ============================================================================
// Module      : rf_write_scheduler
// Description : Initialises x1..x31 after reset, then merges pipeline
//               writebacks with queued long-latency results onto one RF port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_write_scheduler
  import rf_sched_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 2,
  parameter int          STARVE_LIMIT = 8,
  parameter logic [31:0] SP_INIT      = c_sp_init,
  parameter logic [31:0] GP_INIT      = c_gp_init
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data,
  output logic        init_busy,
  output logic [31:0] busy_mask,
  output logic        stall_req
);

  localparam int c_cw = $clog2(FIFO_DEPTH) + 1;
  localparam int c_sw = $clog2(STARVE_LIMIT + 1);

  sched_state_t                       r_state;
  sched_state_t                       w_state_nxt;
  logic [c_reg_aw-1:0]                r_init_idx;
  logic [c_reg_aw-1:0]                w_init_idx_nxt;
  logic                               w_sel_we;
  logic [c_reg_aw-1:0]                w_sel_rd;
  logic [31:0]                        w_sel_data;
  logic                               w_pop;
  logic                               w_push;
  logic                               w_lu_ready;
  logic                               r_rf_we;
  logic [c_reg_aw-1:0]                r_rf_rd;
  logic [31:0]                        r_rf_data;
  logic [c_sw-1:0]                    r_starve;
  logic [c_num_regs-1:0]              w_busy_mask;
  logic [c_reg_aw-1:0]                w_head_rd;
  logic [31:0]                        w_head_data;
  logic [c_cw-1:0]                    w_count;
  logic                               w_empty;
  logic [FIFO_DEPTH-1:0][c_reg_aw-1:0] w_ent_rd;
  logic [FIFO_DEPTH-1:0]              w_ent_vld;

  assign w_lu_ready = (r_state == ST_RUN) && (w_count < c_cw'(FIFO_DEPTH));
  assign w_push     = lu_valid && w_lu_ready && (lu_rd != '0);

  rf_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (c_reg_aw),
    .DW    (32)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_rd   (lu_rd),
    .i_push_data (lu_data),
    .i_pop       (w_pop),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data),
    .o_count     (w_count),
    .o_empty     (w_empty),
    .o_ent_rd    (w_ent_rd),
    .o_ent_vld   (w_ent_vld)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_init_idx_nxt = r_init_idx;
    w_sel_we       = 1'b0;
    w_sel_rd       = '0;
    w_sel_data     = '0;
    w_pop          = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_sel_we       = 1'b1;
        w_sel_rd       = r_init_idx;
        w_sel_data     = (r_init_idx == 5'd2) ? SP_INIT :
                         (r_init_idx == 5'd3) ? GP_INIT : 32'h0;
        w_init_idx_nxt = r_init_idx + 5'd1;
        if (r_init_idx == 5'd31) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // A writeback to x0 is a no-op, so the queue head may take the slot.
        if (wb_valid && (wb_rd != '0)) begin
          w_sel_we   = 1'b1;
          w_sel_rd   = wb_rd;
          w_sel_data = wb_data;
        end else if (!w_empty) begin
          w_sel_we   = 1'b1;
          w_sel_rd   = w_head_rd;
          w_sel_data = w_head_data;
          w_pop      = 1'b1;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_INIT;
      r_init_idx <= 5'd1;
      r_rf_we    <= 1'b0;
      r_rf_rd    <= '0;
      r_rf_data  <= '0;
      r_starve   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_idx <= w_init_idx_nxt;
      r_rf_we    <= w_sel_we;
      r_rf_rd    <= w_sel_rd;
      r_rf_data  <= w_sel_data;
      if (w_empty || w_pop)
        r_starve <= '0;
      else if (r_starve < c_sw'(STARVE_LIMIT))
        r_starve <= r_starve + c_sw'(1);
    end
  end

  always_comb begin
    w_busy_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (w_ent_vld[i]) w_busy_mask = w_busy_mask | rd_decode(w_ent_rd[i]);
  end

  assign lu_ready  = w_lu_ready;
  assign rf_we     = r_rf_we;
  assign rf_rd     = r_rf_rd;
  assign rf_data   = r_rf_data;
  assign init_busy = (r_state == ST_INIT);
  assign busy_mask = w_busy_mask;
  assign stall_req = (r_starve >= c_sw'(STARVE_LIMIT));

endmodule

`default_nettype wire

// File: doc/rf_write_scheduler.md
RF_WRITE_SCHEDULER -- requirements
Module: rf_write_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning long-latency write holding-queue entries (power of two, 2..8).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, meaning the number of cycles a queue head may wait before stall_req is raised.
REQ-003 SHALL have parameter SP_INIT, default 32'h0000_01F4, meaning the x2 reset value.
REQ-004 SHALL have parameter GP_INIT, default 32'h1000_0000, meaning the x3 reset value.
REQ-005 SHALL use one clock; reset is synchronous and active-low; ports: clk in 1 (clock); rst in 1 (synchronous active-low reset).
REQ-006 SHALL have port wb_valid in 1: pipeline writeback request; no backpressure.
REQ-007 SHALL have port wb_rd in 5: writeback destination.
REQ-008 SHALL have port wb_data in 32: writeback value.
REQ-009 SHALL have port lu_valid in 1: long-latency unit (load/mul/div) result valid.
REQ-010 SHALL have port lu_ready out 1: scheduler accepts the lu result this cycle.
REQ-011 SHALL have port lu_rd in 5: long-latency destination.
REQ-012 SHALL have port lu_data in 32: long-latency value.
REQ-013 SHALL have port rf_we out 1: register-file WriteEnable.
REQ-014 SHALL have port rf_rd out 5: register-file rd.
REQ-015 SHALL have port rf_data out 32: register-file data.
REQ-016 SHALL have port init_busy out 1: register-file initialisation in progress; pipeline holds.
REQ-017 SHALL have port busy_mask out 32: bit n set while a queued write targets xn.
REQ-018 SHALL have port stall_req out 1: pipeline must insert bubbles so the queue drains.

Function
REQ-019 SHALL implement FSM states INIT and RUN; reset enters INIT.
REQ-020 In INIT: SHALL issue one write per cycle to x1..x31 in ascending order with value 0, except x2=SP_INIT and x3=GP_INIT; x0 is never written; after the x31 write the FSM moves to RUN.
REQ-021 In INIT: SHALL hold init_busy=1 and lu_ready=0, and ignore wb_valid.
REQ-022 SHALL register rf_we/rf_rd/rf_data: a write selected in cycle t is presented in cycle t+1, held for exactly one cycle.
REQ-023 In RUN: priority SHALL be 1) wb_valid with wb_rd!=0, 2) queue head, 3) none (rf_we=0).
REQ-024 SHALL ignore wb_valid with wb_rd=0 (no write) and let the queue head use the slot in that cycle.
REQ-025 SHALL drive lu_ready = (state==RUN) and (queue count < FIFO_DEPTH), computed from registered count; push in the same cycle as a pop is legal.
REQ-026 SHALL accept a handshake with lu_rd=0 and discard it (no enqueue, no busy_mask bit).
REQ-027 SHALL keep queue order FIFO; wrap-around of read/write pointers SHALL not reorder or lose entries.
REQ-028 busy_mask SHALL equal the OR of decoded rd over valid queue entries, updated the cycle after push/pop; duplicate rd entries keep the bit set until the last one pops.
REQ-029 SHALL count consecutive cycles the queue is non-empty without a pop; stall_req SHALL assert when the count reaches STARVE_LIMIT and deassert the cycle after the next pop; the counter clears on pop or empty.
REQ-030 SHALL treat a wb write matching a queued rd as a write only, with no queue change; ordering is enforced upstream via busy_mask.

Reset
REQ-031 With rst=0 at a clock edge: rf_we=0, rf_rd=0, rf_data=0, lu_ready=0, busy_mask=0, stall_req=0, init_busy=1, queue emptied, starve counter=0, init index=1.
REQ-032 Reset asserted mid-INIT or mid-RUN SHALL discard queued entries and restart INIT at x1 after release.

Structure
REQ-033 Package rf_sched_pkg SHALL hold the state encoding, the register-count/address-width constants, and the SP_INIT/GP_INIT defaults.
REQ-034 Sub-module rf_wr_fifo (FIFO_DEPTH x {5b rd, 32b data}, count, full/empty) SHALL implement the queue; arbitration, FSM, busy_mask and starve logic stay in the top.

Verification
REQ-035 Reset release: rf_we pulses 31 consecutive cycles for x1..x31; x2=0x1F4, x3=0x10000000, others 0; init_busy falls after the x31 write; lu_ready=0 throughout.
REQ-036 RUN, wb_valid rd=5 data=0xAA and lu_valid rd=6 data=0xBB same cycle: x5 written at t+1, x6 at t+2; busy_mask[6]=1 for one cycle.
REQ-037 wb_valid every cycle, lu pushes rd=7,8: lu_ready drops when count=2; stall_req rises after 8 waiting cycles; wb idle -> x7 then x8 written; stall_req clears.
REQ-038 lu rd=0 accepted: no rf_we, busy_mask stays 0.
REQ-039 Two pushes with rd=9: busy_mask[9] stays 1 until the second pop.
REQ-040 rst=0 with 2 entries queued mid-RUN: queue discarded, INIT restarts at x1 with no stale write.
